// File: rtl/uart_pkg.sv
// UART shared definitions: serializer state encoding, bit timing and frame shape.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  // Clock cycles per line bit, truncated toward zero.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and head-of-queue read port.
// Latency: a pushed word is visible at o_head one cycle after the push edge.
// Backpressure: a push while full or a pop while empty is silently dropped.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks push minus pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer.
// Latency: byte accepted into an empty idle block drives the line low after the next edge.
// Backpressure: o_ready drops when the FIFO holds DEPTH bytes; a same-cycle pop does not reopen it.
module uart_tx_fifo #(
  parameter int CLK_HZ = 125000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_uart_tx,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level
);

  import uart_pkg::*;

  localparam int             CPB      = clks_per_bit(CLK_HZ, BAUD);
  localparam int             CW       = $clog2(CPB + 1);
  localparam logic [CW-1:0]  CPB_LAST = CW'(CPB - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_baud_end;
  logic [2:0]    w_bit_inc;
  logic [7:0]    w_head;

  assign o_ready    = !w_full;
  assign w_push     = i_valid && o_ready;
  assign w_baud_end = (r_baud == CPB_LAST);
  assign w_bit_inc  = r_bit + 3'd1;
  assign o_uart_tx  = r_tx;
  assign o_busy     = (r_state != ST_IDLE) || !w_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (i_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (o_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Serializer state register; line idles high out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic; the line value is computed one cycle ahead so o_uart_tx is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + CW'(1);
          w_tx_nxt   = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_tx_nxt  = r_shift[w_bit_inc];
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
          w_tx_nxt   = r_shift[r_bit];
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
          w_tx_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
